// File: rtl/seg7_scan_driver.sv
// Time-multiplexed common-anode 7-segment scanner with hex decode, leading-zero blanking,
// a per-frame input snapshot and a dark guard interval at the start of every digit slot.
module seg7_scan_driver #(
    parameter int NUM_DIGITS = 8,
    parameter int SCAN_DIV   = 100000,
    parameter int GUARD      = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] i_data,
    input  logic [NUM_DIGITS-1:0]   i_dp,
    input  logic [NUM_DIGITS-1:0]   i_digit_en,
    input  logic                    i_blank_lz,
    output logic [7:0]              o_seg,
    output logic [NUM_DIGITS-1:0]   o_an,
    output logic                    o_frame
);

    localparam int CW = $clog2(SCAN_DIV);
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

    logic [CW-1:0]           cnt_q, cnt_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic                    load_pend_q, load_pend_d;
    logic [4*NUM_DIGITS-1:0] snap_data_q, snap_data_d;
    logic [NUM_DIGITS-1:0]   snap_dp_q, snap_dp_d;
    logic [NUM_DIGITS-1:0]   snap_en_q, snap_en_d;
    logic                    snap_lz_q, snap_lz_d;
    logic [7:0]              seg_q, seg_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic                    frame_q, frame_d;

    logic                    wrap;
    logic                    capture;
    logic                    past_guard;
    logic                    zero_run;
    logic [NUM_DIGITS-1:0]   lz_blank;

    function automatic logic [7:0] hex_to_seg(input logic [3:0] nib);
        logic [7:0] pat;
        case (nib)
            4'h0: pat = 8'hC0;
            4'h1: pat = 8'hF9;
            4'h2: pat = 8'hA4;
            4'h3: pat = 8'hB0;
            4'h4: pat = 8'h99;
            4'h5: pat = 8'h92;
            4'h6: pat = 8'h82;
            4'h7: pat = 8'hF8;
            4'h8: pat = 8'h80;
            4'h9: pat = 8'h90;
            4'hA: pat = 8'h88;
            4'hB: pat = 8'h83;
            4'hC: pat = 8'hC6;
            4'hD: pat = 8'hA1;
            4'hE: pat = 8'h86;
            default: pat = 8'h8E;
        endcase
        return pat;
    endfunction

    generate
        if (GUARD == 0) begin : g_no_guard
            assign past_guard = 1'b1;
        end else begin : g_guard
            assign past_guard = (cnt_q >= CW'(GUARD));
        end
    endgenerate

    always_comb begin
        wrap        = (cnt_q == CNT_LAST);
        cnt_d       = wrap ? '0 : cnt_q + 1'b1;
        idx_d       = idx_q;
        if (wrap) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end

        // Snapshot only at frame boundaries so one frame never mixes old and new values.
        capture     = load_pend_q || (wrap && (idx_q == IDX_LAST));
        load_pend_d = 1'b0;
        frame_d     = capture;
        snap_data_d = snap_data_q;
        snap_dp_d   = snap_dp_q;
        snap_en_d   = snap_en_q;
        snap_lz_d   = snap_lz_q;
        if (capture) begin
            snap_data_d = i_data;
            snap_dp_d   = i_dp;
            snap_en_d   = i_digit_en;
            snap_lz_d   = i_blank_lz;
        end

        // Disabled digits still take part in the zero run; enable only gates lighting.
        zero_run = 1'b1;
        lz_blank = '0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            zero_run    = zero_run && (snap_data_q[4*k +: 4] == 4'h0);
            lz_blank[k] = snap_lz_q && (k != 0) && zero_run;
        end

        seg_d = 8'hFF;
        an_d  = '1;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if ((idx_q == IW'(k)) && past_guard && snap_en_q[k] && !lz_blank[k]) begin
                an_d[k] = 1'b0;
                seg_d   = hex_to_seg(snap_data_q[4*k +: 4]);
                if (snap_dp_q[k]) begin
                    seg_d[7] = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q       <= '0;
            idx_q       <= '0;
            load_pend_q <= 1'b1;
            snap_data_q <= '0;
            snap_dp_q   <= '0;
            snap_en_q   <= '0;
            snap_lz_q   <= 1'b0;
            seg_q       <= 8'hFF;
            an_q        <= '1;
            frame_q     <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            load_pend_q <= load_pend_d;
            snap_data_q <= snap_data_d;
            snap_dp_q   <= snap_dp_d;
            snap_en_q   <= snap_en_d;
            snap_lz_q   <= snap_lz_d;
            seg_q       <= seg_d;
            an_q        <= an_d;
            frame_q     <= frame_d;
        end
    end

    assign o_seg   = seg_q;
    assign o_an    = an_q;
    assign o_frame = frame_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: a 4-digit instance and a 1-digit instance, checked every cycle
// against a frame/slot arithmetic model plus fixed expectations for the named scenarios.
module tb_seg7_scan_driver;

    localparam int ND = 4;
    localparam int SD = 4;
    localparam int G  = 1;
    localparam int F  = ND * SD;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic [15:0] a_data = 16'h1234;
    logic [3:0]  a_dp   = 4'h0;
    logic [3:0]  a_en   = 4'hF;
    logic        a_lz   = 1'b0;
    logic [7:0]  a_seg;
    logic [3:0]  a_an;
    logic        a_frame;

    logic [3:0]  b_data = 4'h0;
    logic        b_dp   = 1'b0;
    logic        b_en   = 1'b1;
    logic        b_lz   = 1'b0;
    logic [7:0]  b_seg;
    logic        b_an;
    logic        b_frame;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] seg_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                 8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    seg7_scan_driver #(.NUM_DIGITS(ND), .SCAN_DIV(SD), .GUARD(G)) u_dut_a (
        .clk(clk), .rst(rst), .i_data(a_data), .i_dp(a_dp), .i_digit_en(a_en),
        .i_blank_lz(a_lz), .o_seg(a_seg), .o_an(a_an), .o_frame(a_frame)
    );

    seg7_scan_driver #(.NUM_DIGITS(1), .SCAN_DIV(SD), .GUARD(G)) u_dut_b (
        .clk(clk), .rst(rst), .i_data(b_data), .i_dp(b_dp), .i_digit_en(b_en),
        .i_blank_lz(b_lz), .o_seg(b_seg), .o_an(b_an), .o_frame(b_frame)
    );

    always #5 clk = ~clk;

    // Reference model: edge e after reset release displays position p=e-1 of the scan,
    // using the snapshot taken on the most recent capture edge before e.
    int          e_a = 0;
    int          e_b = 0;
    logic [15:0] ma_data = '0;
    logic [3:0]  ma_dp = '0, ma_en = '0;
    logic        ma_lz = 1'b0;
    logic [3:0]  mb_data = '0;
    logic        mb_dp = 1'b0, mb_en = 1'b0, mb_lz = 1'b0;
    logic [23:0] exp_a = 24'hFFFFFF;
    logic [23:0] exp_b = 24'hFFFFFF;
    logic        exp_a_frame = 1'b0;
    logic        exp_b_frame = 1'b0;

    function automatic logic [23:0] model_out(input int nd, input int e, input logic [15:0] d,
                                              input logic [3:0] dp, input logic [3:0] en,
                                              input logic lz);
        logic [15:0] an;
        logic [15:0] upper;
        logic [7:0]  seg;
        int          p, c, k;
        an  = 16'hFFFF;
        seg = 8'hFF;
        p   = e - 1;
        c   = p % SD;
        k   = (p / SD) % nd;
        upper = d >> (4 * k);
        if (c >= G && en[k] && !(lz && k > 0 && upper == 16'h0)) begin
            an[k] = 1'b0;
            seg   = seg_tab[upper[3:0]];
            if (dp[k]) seg[7] = 1'b0;
        end
        return {an, seg};
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            e_a = 0; e_b = 0;
            ma_data = '0; ma_dp = '0; ma_en = '0; ma_lz = 1'b0;
            mb_data = '0; mb_dp = 1'b0; mb_en = 1'b0; mb_lz = 1'b0;
            exp_a = 24'hFFFFFF; exp_b = 24'hFFFFFF;
            exp_a_frame = 1'b0; exp_b_frame = 1'b0;
        end else begin
            e_a++;
            e_b++;
            exp_a       = model_out(ND, e_a, ma_data, ma_dp, ma_en, ma_lz);
            exp_a_frame = (e_a == 1) || (e_a % F == 0);
            if (exp_a_frame) begin
                ma_data = a_data; ma_dp = a_dp; ma_en = a_en; ma_lz = a_lz;
            end
            exp_b       = model_out(1, e_b, {12'h0, mb_data}, {3'b0, mb_dp}, {3'b0, mb_en}, mb_lz);
            exp_b_frame = (e_b == 1) || (e_b % SD == 0);
            if (exp_b_frame) begin
                mb_data = b_data; mb_dp = b_dp; mb_en = b_en; mb_lz = b_lz;
            end
        end
    end

    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_checks++;
        if (a_seg !== 8'hFF || a_an !== 4'hF || a_frame !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_a: seg=%h an=%h frame=%b, expected seg=FF an=F frame=0", a_seg, a_an, a_frame);
        end
        n_checks++;
        if (b_seg !== 8'hFF || b_an !== 1'b1 || b_frame !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_b: seg=%h an=%b frame=%b, expected seg=FF an=1 frame=0", b_seg, b_an, b_frame);
        end
        for (int r = 0; r < 2; r++) begin
            rst = 1'b0;
            @(negedge clk);
            n_checks++;
            if (a_frame !== 1'b1 || a_an !== 4'hF) begin
                n_fail++;
                $display("FAIL first_edge[%0d]: frame=%b an=%h, expected frame=1 an=F", r, a_frame, a_an);
            end
            @(negedge clk);
            n_checks++;
            if (a_an !== 4'hE || a_seg !== 8'h99 || a_frame !== 1'b0) begin
                n_fail++;
                $display("FAIL after_guard[%0d]: an=%h seg=%h frame=%b, expected an=E seg=99 frame=0", r, a_an, a_seg, a_frame);
            end
            if (r == 0) begin
                repeat (4) @(negedge clk);
                @(posedge clk);
                #2 rst = 1'b1;
                #1;
                n_checks++;
                if (a_seg !== 8'hFF || a_an !== 4'hF || a_frame !== 1'b0) begin
                    n_fail++;
                    $display("FAIL reset_mid_slot: seg=%h an=%h frame=%b, expected seg=FF an=F frame=0", a_seg, a_an, a_frame);
                end
                @(negedge clk);
            end
        end
    endtask

    task automatic test_scan();
        int frames = 0;
        int got = 0;
        logic [3:0] an_seq [4] = '{4'hE, 4'hD, 4'hB, 4'h7};
        logic [7:0] seg_seq [4] = '{8'h99, 8'hB0, 8'hA4, 8'hF9};
        a_data = 16'h1234; a_dp = 4'h0; a_en = 4'hF; a_lz = 1'b0;
        for (int c = 0; c < 32; c++) begin
            @(negedge clk);
            n_checks++;
            if (a_seg !== exp_a[7:0] || a_an !== exp_a[11:8] || a_frame !== exp_a_frame) begin
                n_fail++;
                $display("FAIL scan_model t=%0t: seg=%h an=%h frame=%b, expected seg=%h an=%h frame=%b",
                         $time, a_seg, a_an, a_frame, exp_a[7:0], exp_a[11:8], exp_a_frame);
            end
            if (a_frame) frames++;
        end
        n_checks++;
        if (frames != 2) begin
            n_fail++;
            $display("FAIL scan_frame_rate: %0d pulses in 32 cycles, expected 2", frames);
        end
        for (int c = 0; c < 40 && got == 0; c++) begin
            @(negedge clk);
            got = int'(a_frame);
        end
        n_checks++;
        if (got == 0) begin
            n_fail++;
            $display("FAIL scan_wait_frame: no o_frame within 40 cycles, expected one");
        end
        for (int i = 0; i < F; i++) begin
            @(negedge clk);
            n_checks++;
            if (i % SD == 0) begin
                if (a_an !== 4'hF || a_seg !== 8'hFF) begin
                    n_fail++;
                    $display("FAIL scan_guard[%0d]: an=%h seg=%h, expected an=F seg=FF", i, a_an, a_seg);
                end
            end else if (a_an !== an_seq[i / SD] || a_seg !== seg_seq[i / SD]) begin
                n_fail++;
                $display("FAIL scan_slot[%0d]: an=%h seg=%h, expected an=%h seg=%h",
                         i, a_an, a_seg, an_seq[i / SD], seg_seq[i / SD]);
            end
        end
    endtask

    task automatic test_blank_dp_en();
        int lit1 = 0;
        logic [15:0] pat_data [3] = '{16'h00A0, 16'h0000, 16'h0305};
        logic [3:0]  pat_dp   [3] = '{4'h0, 4'h0, 4'b0001};
        logic [3:0]  pat_en   [3] = '{4'hF, 4'hF, 4'hF};
        for (int s = 0; s < 4; s++) begin
            if (s < 3) begin
                a_data = pat_data[s]; a_dp = pat_dp[s]; a_en = pat_en[s]; a_lz = 1'b1;
            end else begin
                a_data = 16'($urandom); a_dp = 4'b0010; a_en = 4'b1101; a_lz = 1'($urandom);
            end
            for (int c = 0; c < 2 * F; c++) begin
                @(negedge clk);
                n_checks++;
                if (a_seg !== exp_a[7:0] || a_an !== exp_a[11:8] || a_frame !== exp_a_frame) begin
                    n_fail++;
                    $display("FAIL blank_model[%0d] t=%0t: seg=%h an=%h frame=%b, expected seg=%h an=%h frame=%b",
                             s, $time, a_seg, a_an, a_frame, exp_a[7:0], exp_a[11:8], exp_a_frame);
                end
                if (c >= F && s == 0 && (a_an[3] === 1'b0 || a_an[2] === 1'b0)) begin
                    n_checks++; n_fail++;
                    $display("FAIL blank_lz_digits: an=%h, expected digits 3,2 dark", a_an);
                end
                if (c >= F && s == 3 && a_an[1] === 1'b0) begin
                    n_checks++; n_fail++;
                    $display("FAIL en_disabled_digit: an=%h, expected digit 1 dark", a_an);
                end
                if (c >= F && s == 0 && a_an === 4'hD && a_seg === 8'h88) lit1++;
            end
        end
        n_checks++;
        if (lit1 != 3) begin
            n_fail++;
            $display("FAIL blank_digit1_88: %0d lit cycles, expected 3", lit1);
        end
    endtask

    task automatic test_tear();
        int got;
        int bad = 0;
        a_data = 16'h1111; a_dp = 4'h0; a_en = 4'hF; a_lz = 1'b0;
        for (int f = 0; f < 2; f++) begin
            got = 0;
            for (int c = 0; c < 40 && got == 0; c++) begin
                @(negedge clk);
                got = int'(a_frame);
            end
            n_checks++;
            if (got == 0) begin
                n_fail++;
                $display("FAIL tear_wait_frame[%0d]: no o_frame within 40 cycles", f);
            end
        end
        repeat (5) @(negedge clk);
        a_data = 16'h2222;
        got = 0;
        for (int c = 0; c < 40 && got == 0; c++) begin
            @(negedge clk);
            if (a_an !== 4'hF && a_seg !== 8'hF9) bad++;
            got = int'(a_frame);
        end
        n_checks++;
        if (got == 0 || bad != 0) begin
            n_fail++;
            $display("FAIL tear_old_frame: frame_seen=%0d wrong_lit=%0d, expected 1 and 0", got, bad);
        end
        bad = 0;
        for (int c = 0; c < F; c++) begin
            @(negedge clk);
            if (a_an !== 4'hF && a_seg !== 8'hA4) bad++;
            if (a_seg !== exp_a[7:0] || a_an !== exp_a[11:8]) bad++;
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL tear_new_frame: %0d wrong cycles, expected 0 (A4 on all digits)", bad);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 160; c++) begin
            @(negedge clk);
            n_checks++;
            if (a_seg !== exp_a[7:0] || a_an !== exp_a[11:8] || a_frame !== exp_a_frame) begin
                n_fail++;
                $display("FAIL random_model t=%0t: seg=%h an=%h frame=%b, expected seg=%h an=%h frame=%b",
                         $time, a_seg, a_an, a_frame, exp_a[7:0], exp_a[11:8], exp_a_frame);
            end
            n_checks++;
            if ($countones(~a_an) > 1) begin
                n_fail++;
                $display("FAIL random_onehot: an=%h, expected at most one low bit", a_an);
            end
            if ($urandom_range(7) == 0) begin
                a_data = ($urandom_range(1) == 0) ? 16'($urandom) : 16'($urandom_range(255));
                a_dp = 4'($urandom); a_en = 4'($urandom); a_lz = 1'($urandom);
            end
        end
    endtask

    task automatic test_decode_sweep();
        int seen;
        for (int v = 0; v < 16; v++) begin
            b_data = 4'(v); b_dp = 1'($urandom); b_en = 1'b1; b_lz = 1'($urandom);
            seen = 0;
            for (int c = 0; c < 2 * SD; c++) begin
                @(negedge clk);
                n_checks++;
                if (b_seg !== exp_b[7:0] || b_an !== exp_b[8] || b_frame !== exp_b_frame) begin
                    n_fail++;
                    $display("FAIL sweep_model[%0d] t=%0t: seg=%h an=%b frame=%b, expected seg=%h an=%b frame=%b",
                             v, $time, b_seg, b_an, b_frame, exp_b[7:0], exp_b[8], exp_b_frame);
                end
                if (b_an === 1'b0 && b_seg[6:0] === seg_tab[v][6:0] && b_seg[7] === ~b_dp) seen = 1;
            end
            n_checks++;
            if (seen == 0) begin
                n_fail++;
                $display("FAIL sweep_pattern[%0d]: pattern %h never shown", v, seg_tab[v]);
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_scan();
        test_blank_dp_en();
        test_tear();
        test_random();
        test_decode_sweep();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
